// File: rtl/rom_dl_router.sv
// ROM download router: decodes the HPS ioctl byte stream into NCH SDRAM regions, packs bytes
// into BPW-byte words handed off over toggle req/ack, and sequences the game core reset.
module rom_dl_router #(
    parameter int                NCH       = 2,
    parameter int                AW        = 25,
    parameter int                BPW       = 2,
    parameter logic [7:0]        ROM_INDEX = 8'd0,
    parameter logic [NCH*AW-1:0] CH_BASE   = {25'h10000, 25'h0},
    parameter logic [NCH*AW-1:0] CH_SIZE   = {25'h0C000, 25'h10000},
    parameter int                RST_HOLD  = 65535
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [AW-1:0]        ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_ack,
    output logic [NCH*AW-1:0]    ch_addr,
    output logic [NCH*8*BPW-1:0] ch_data,
    output logic [NCH*BPW-1:0]   ch_be,
    output logic                 dl_done,
    output logic                 rom_loaded,
    output logic                 core_reset,
    output logic                 overflow,
    output logic [AW-1:0]        byte_count
);

    localparam int LW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SH = $clog2(BPW);
    localparam int DW = 8 * BPW;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t state, state_next;

    logic           wr_d, dl_d;
    logic           rom_dl, dl_rise, dl_fall, byte_ok, start, flush_done, last_lane;
    logic [NCH-1:0] req, busy, hit, issued, pend;
    logic [AW-1:0]  offset, word_addr;
    logic [LW-1:0]  lane;
    logic [BPW-1:0] lane_bit;
    logic [DW-1:0]  lane_mask, lane_data;
    logic [BPW-1:0] be_q   [NCH];
    logic [DW-1:0]  data_q [NCH];
    logic [AW-1:0]  addr_q [NCH];
    logic [HW-1:0]  hold;

    // Downloads for other indices never reach the state machine or the byte path.
    assign rom_dl  = ioctl_download && (ioctl_index == ROM_INDEX);
    assign dl_rise = rom_dl && !dl_d;
    assign dl_fall = !rom_dl && dl_d;
    assign byte_ok = ioctl_wr && !wr_d && rom_dl;
    assign busy    = req ^ ch_ack;
    assign start   = (state == IDLE) && dl_rise;

    // Scan downward so the lowest-indexed matching region wins.
    always_comb begin
        hit    = '0;
        offset = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ioctl_addr >= CH_BASE[i*AW +: AW] &&
                (ioctl_addr - CH_BASE[i*AW +: AW]) < CH_SIZE[i*AW +: AW]) begin
                hit    = '0;
                hit[i] = 1'b1;
                offset = ioctl_addr - CH_BASE[i*AW +: AW];
            end
        end
    end

    generate
        if (BPW > 1) begin : g_lane
            assign lane = offset[LW-1:0];
        end else begin : g_lane_one
            assign lane = 1'b0;
        end
    endgenerate

    assign word_addr = offset >> SH;
    assign last_lane = (lane == LW'(BPW - 1));
    assign lane_bit  = BPW'(1) << lane;
    assign lane_mask = DW'(8'hFF) << {lane, 3'b000};
    assign lane_data = DW'(ioctl_dout) << {lane, 3'b000};

    always_comb begin
        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = (|be_q[i]) && !issued[i];
        end
    end

    assign flush_done = (state == FLUSH) && (busy == '0) && (pend == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dl_rise)    state_next = LOAD;
            LOAD:    if (dl_fall)    state_next = FLUSH;
            FLUSH:   if (flush_done) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Word buffers: a buffer is frozen while its channel is busy; be only restarts with the next word.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req    <= '0;
            issued <= '0;
            for (int i = 0; i < NCH; i++) begin
                be_q[i]   <= '0;
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (byte_ok && hit[i] && !busy[i]) begin
                    be_q[i]   <= ((start || issued[i]) ? '0 : be_q[i]) | lane_bit;
                    data_q[i] <= ((start ? '0 : data_q[i]) & ~lane_mask) | lane_data;
                    addr_q[i] <= word_addr;
                    issued[i] <= last_lane;
                    if (last_lane) begin
                        req[i] <= ~req[i];
                    end
                end else if (start) begin
                    be_q[i]   <= '0;
                    data_q[i] <= '0;
                    addr_q[i] <= '0;
                    issued[i] <= 1'b0;
                end else if (state == FLUSH && !busy[i] && pend[i]) begin
                    req[i]    <= ~req[i];
                    issued[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_d       <= 1'b0;
            dl_d       <= 1'b0;
            ioctl_wait <= 1'b0;
            dl_done    <= 1'b0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            hold       <= '0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            wr_d       <= ioctl_wr;
            dl_d       <= rom_dl;
            ioctl_wait <= |busy;
            dl_done    <= flush_done;
            overflow   <= !start && (overflow || (byte_ok && |(hit & busy)));
            byte_count <= (start ? '0 : byte_count) + AW'(byte_ok);
            if (start) begin
                rom_loaded <= 1'b0;
            end else if (flush_done) begin
                rom_loaded <= 1'b1;
            end
            if (start) begin
                hold <= '0;
            end else if (flush_done) begin
                hold <= HW'(RST_HOLD);
            end else if (hold != '0) begin
                hold <= hold - HW'(1);
            end
            core_reset <= ioctl_download || (state != IDLE) || (hold != '0) || !rom_loaded;
        end
    end

    assign ch_req = req;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_out
            assign ch_data[g*DW +: DW]   = data_q[g];
            assign ch_be[g*BPW +: BPW]   = be_q[g];
            assign ch_addr[g*AW +: AW]   = addr_q[g];
        end
    endgenerate

endmodule
